// File: rtl/ascon_hash_ctrl.sv
// ascon_hash_ctrl: Ascon-Hash sponge controller (256-bit digest, 64-bit rate).
// Holds the 320-bit state, sequences the external permutation core via
// perm_clr/perm_start/perm_fin, absorbs a byte-granular stream with 10* padding
// and streams four 64-bit digest words.
// Optional build macro ASCON_HASH_PRECOMP_IV_EN: load the post-init state
// directly and skip the init permutation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | write initial state, choose first permutation return
// PCLR     | perm_clr pulse, state presented on perm_state
// PSTART   | perm_start pulse
// PWAIT    | wait for perm_fin, capture result, branch on ret
// ABSORB   | msg_ready high, accept one message word
// PAD      | extra 0x80 block after a full last word
// SQUEEZE  | present digest word x0 until dig_ready
module ascon_hash_ctrl #(
  parameter logic [4:0]  ROUNDS = 5'd12,
  parameter logic [63:0] IV     = 64'h00400c0000000100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [63:0]  msg_data,
  input  logic         msg_last,
  input  logic [3:0]   msg_bytes,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [63:0]  dig_data,
  output logic         dig_last,
  output logic         perm_clr,
  output logic         perm_start,
  output logic [4:0]   perm_round,
  output logic [319:0] perm_state,
  input  logic [319:0] perm_state_out,
  input  logic         perm_fin
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PCLR, S_PSTART, S_PWAIT, S_ABSORB, S_PAD, S_SQUEEZE
  } state_t;

  typedef enum logic [1:0] {RET_ABS, RET_PAD, RET_SQZ} ret_t;

`ifdef ASCON_HASH_PRECOMP_IV_EN
  localparam logic [319:0] POST_INIT = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                        64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                        64'h348fa5c9d525e140};
`endif

  localparam logic [63:0] PAD_TOP = 64'h8000000000000000;

  state_t         fsm_q, fsm_d;
  ret_t           ret_q, ret_d;
  logic [319:0]   st_q, st_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           msg_ready_q, msg_ready_d;
  logic           dig_valid_q, dig_valid_d;
  logic [63:0]    dig_data_q, dig_data_d;
  logic           dig_last_q, dig_last_d;
  logic           perm_clr_q, perm_clr_d;
  logic           perm_start_q, perm_start_d;

  logic [3:0]     kk;
  logic [63:0]    last_mask;
  logic [63:0]    last_pad;

  // Mask for the valid bytes of a short last word and the 0x80 pad byte after them
  always_comb begin
    kk        = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    last_mask = '0;
    last_pad  = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < kk)  last_mask[63-8*b -: 8] = 8'hff;
      if (4'(b) == kk) last_pad[63-8*b -: 8]  = 8'h80;
    end
  end

  // Next-state, state-register and registered-output computation
  always_comb begin
    fsm_d = fsm_q;
    ret_d = ret_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) fsm_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef ASCON_HASH_PRECOMP_IV_EN
        st_d  = POST_INIT;
        fsm_d = S_ABSORB;
`else
        st_d  = {IV, 256'd0};
        ret_d = RET_ABS;
        fsm_d = S_PCLR;
`endif
      end
      S_PCLR:   fsm_d = S_PSTART;
      S_PSTART: fsm_d = S_PWAIT;
      S_PWAIT: begin
        if (perm_fin) begin
          st_d = perm_state_out;
          case (ret_q)
            RET_PAD: fsm_d = S_PAD;
            RET_SQZ: fsm_d = S_SQUEEZE;
            default: fsm_d = S_ABSORB;
          endcase
        end
      end
      S_ABSORB: begin
        if (msg_valid && msg_ready_q) begin
          fsm_d = S_PCLR;
          if (!msg_last) begin
            st_d[319:256] = st_q[319:256] ^ msg_data;
            ret_d         = RET_ABS;
          end else if (kk == 4'd8) begin
            st_d[319:256] = st_q[319:256] ^ msg_data;
            ret_d         = RET_PAD;
          end else begin
            st_d[319:256] = st_q[319:256] ^ (msg_data & last_mask) ^ last_pad;
            ret_d         = RET_SQZ;
          end
        end
      end
      S_PAD: begin
        st_d[319:256] = st_q[319:256] ^ PAD_TOP;
        ret_d         = RET_SQZ;
        fsm_d         = S_PCLR;
      end
      S_SQUEEZE: begin
        if (dig_ready) begin
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            fsm_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
            ret_d = RET_SQZ;
            fsm_d = S_PCLR;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    busy_d       = (fsm_d != S_IDLE);
    msg_ready_d  = (fsm_d == S_ABSORB);
    dig_valid_d  = (fsm_d == S_SQUEEZE);
    dig_data_d   = (fsm_d == S_SQUEEZE) ? st_d[319:256] : dig_data_q;
    dig_last_d   = (fsm_d == S_SQUEEZE) && (cnt_d == 2'd3);
    perm_clr_d   = (fsm_d == S_PCLR);
    perm_start_d = (fsm_d == S_PSTART);
  end

  // Single register stage for FSM, sponge state and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      ret_q        <= RET_ABS;
      st_q         <= '0;
      cnt_q        <= 2'd0;
      busy_q       <= 1'b0;
      msg_ready_q  <= 1'b0;
      dig_valid_q  <= 1'b0;
      dig_data_q   <= '0;
      dig_last_q   <= 1'b0;
      perm_clr_q   <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      ret_q        <= ret_d;
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      msg_ready_q  <= msg_ready_d;
      dig_valid_q  <= dig_valid_d;
      dig_data_q   <= dig_data_d;
      dig_last_q   <= dig_last_d;
      perm_clr_q   <= perm_clr_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign busy       = busy_q;
  assign msg_ready  = msg_ready_q;
  assign dig_valid  = dig_valid_q;
  assign dig_data   = dig_data_q;
  assign dig_last   = dig_last_q;
  assign perm_clr   = perm_clr_q;
  assign perm_start = perm_start_q;
  assign perm_round = ROUNDS;
  assign perm_state = st_q;

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Testbench for ascon_hash_ctrl: models the permutation core, feeds random
// messages and checks digests from a sponge-level reference model via a scoreboard.
module tb_ascon_hash_ctrl;
  typedef logic [7:0] u8;
  localparam logic [63:0] IV = 64'h00400c0000000100;
`ifdef ASCON_HASH_PRECOMP_IV_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, busy, msg_valid, msg_ready, msg_last;
  logic [63:0]  msg_data, dig_data;
  logic [3:0]   msg_bytes;
  logic         dig_valid, dig_ready, dig_last, perm_clr, perm_start, perm_fin;
  logic [4:0]   perm_round;
  logic [319:0] perm_state, perm_state_out;

  ascon_hash_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
    .perm_clr(perm_clr), .perm_start(perm_start), .perm_round(perm_round),
    .perm_state(perm_state), .perm_state_out(perm_state_out), .perm_fin(perm_fin)
  );

  int n_checks = 0;
  int n_fail = 0;
  int nstart = 0;
  int n_dig = 0;
  logic [63:0]  exp_d[$];
  logic         exp_l[$];
  logic [319:0] cap_log[$];
  logic         stray = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 0; r < 12; r++) begin
      x2 = x2 ^ {56'd0, 4'(15 - r), 4'(r)};
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1)  ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // Sponge-level reference: pad the byte string, absorb 8-byte blocks, squeeze 4 words
  function automatic void model_push(input u8 m[$]);
    logic [319:0] s;
    logic [63:0]  blk;
    u8            p[$];
    s = ascon_p({IV, 256'd0});
    p = m;
    p.push_back(8'h80);
    while (p.size() % 8 != 0) p.push_back(8'h00);
    for (int i = 0; i < p.size(); i += 8) begin
      blk = '0;
      for (int b = 0; b < 8; b++) blk = {blk[55:0], p[i+b]};
      s[319:256] = s[319:256] ^ blk;
      s = ascon_p(s);
    end
    for (int w = 0; w < 4; w++) begin
      if (w > 0) s = ascon_p(s);
      exp_d.push_back(s[319:256]);
      exp_l.push_back(w == 3);
    end
  endfunction

  function automatic void push_empty_const();
    exp_d.push_back(64'h7346bc14f036e87a); exp_l.push_back(1'b0);
    exp_d.push_back(64'he03d0997913088f5); exp_l.push_back(1'b0);
    exp_d.push_back(64'hf68411434b3cf8b5); exp_l.push_back(1'b0);
    exp_d.push_back(64'h4fa796a80d251f91); exp_l.push_back(1'b1);
  endfunction

  // Permutation core model with random latency; also checks the call protocol
  logic [319:0] cap;
  logic         pend = 1'b0;
  logic         prev_clr = 1'b0;
  int           lat = 0;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      perm_fin = 1'b0;
      prev_clr = 1'b0;
    end else begin
      perm_fin = 1'b0;
      if (stray && !pend) begin
        perm_fin = 1'b1;
        perm_state_out = {10{$urandom}};
      end
      if (pend) begin
        chk("perm_state_stable", 64'(perm_state === cap), 64'd1);
        if (lat == 0) begin
          perm_fin = 1'b1;
          perm_state_out = ascon_p(cap);
          pend = 1'b0;
        end else lat--;
      end
      if (perm_start) begin
        chk("perm_round", 64'(perm_round), 64'd12);
        chk("clr_before_start", 64'(prev_clr), 64'd1);
        cap = perm_state;
        cap_log.push_back(cap);
        pend = 1'b1;
        lat = $urandom_range(0, 4);
        nstart++;
      end
      prev_clr = perm_clr;
    end
  end

  // Digest monitor: pops the scoreboard on each handshake, checks hold while stalled
  logic        pv = 1'b0, pr = 1'b0;
  logic [63:0] pd = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("dig_valid_hold", 64'(dig_valid), 64'd1);
        chk("dig_data_hold", dig_data, pd);
      end
      if (dig_valid && dig_ready) begin
        if (exp_d.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dig_unexpected: got %h expected none", dig_data);
        end else begin
          chk("dig_data", dig_data, exp_d.pop_front());
          chk("dig_last", 64'(dig_last), 64'(exp_l.pop_front()));
        end
        n_dig++;
      end
      pv = dig_valid; pr = dig_ready; pd = dig_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (msg_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL msg_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    repeat ($urandom_range(0, 2)) tick();
    wait_ready();
    msg_valid = 1'b1; msg_data = d; msg_last = last; msg_bytes = nb;
    tick();
    msg_valid = 1'b0; msg_data = {$urandom, $urandom}; msg_last = $urandom_range(0, 1);
  endtask

  task automatic feed(input u8 m[$]);
    int len = m.size();
    int nw = (len == 0) ? 1 : (len + 7) / 8;
    logic [63:0] d;
    logic [3:0]  nb;
    int k;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++)
        d[63-8*b -: 8] = (8*w + b < len) ? m[8*w+b] : 8'($urandom);
      if (w == nw - 1) begin
        k = len - 8 * (nw - 1);
        nb = (k == 8 && $urandom_range(0, 1) == 1) ? 4'(8 + $urandom_range(0, 7)) : 4'(k);
        send_word(d, 1'b1, nb);
      end else begin
        send_word(d, 1'b0, 4'($urandom_range(0, 15)));
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic drain(input bit stall);
    int base = n_dig;
    int guard = 0;
    bit stalled = 0;
    int s0;
    logic [63:0] d0;
    while (n_dig - base < 4 && guard < 3000) begin
      if (stall && !stalled && n_dig - base == 1) begin
        dig_ready = 1'b0;
        if (dig_valid) begin
          stalled = 1; s0 = nstart; d0 = dig_data;
          repeat (20) begin
            tick();
            chk("stall_valid", 64'(dig_valid), 64'd1);
            chk("stall_data", dig_data, d0);
          end
          chk("stall_no_perm", 64'(nstart), 64'(s0));
        end
      end else begin
        dig_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      guard++;
    end
    dig_ready = 1'b0;
    if (n_dig - base < 4) begin
      n_checks++; n_fail++;
      $display("FAIL digest_timeout: got %0d words expected 4", n_dig - base);
    end
    chk("busy_after_digest", 64'(busy), 64'd0);
  endtask

  task automatic run_hash(input u8 m[$], input bit known_empty, input bit stall);
    if (known_empty) push_empty_const(); else model_push(m);
    pulse_start();
    feed(m);
    drain(stall);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    u8 m[$];
    int n0, c0, idx;
    logic [319:0] init_s;
    logic [63:0] x0i;

    rst = 1'b1; start = 1'b0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
    msg_bytes = '0; dig_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_msg_ready", 64'(msg_ready), 64'd0);
    chk("rst_dig_valid", 64'(dig_valid), 64'd0);
    chk("rst_dig_last", 64'(dig_last), 64'd0);
    chk("rst_perm_clr", 64'(perm_clr), 64'd0);
    chk("rst_perm_start", 64'(perm_start), 64'd0);
    chk("rst_dig_data", dig_data, 64'd0);
    chk("rst_perm_state", 64'(perm_state == '0), 64'd1);
    rst = 1'b0;
    tick();

    // Empty message against the known digest
    m.delete();
    run_hash(m, 1'b1, 1'b0);

    // Single full word 00..07: permutation count
    m = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    n0 = nstart;
    run_hash(m, 1'b0, 1'b0);
    chk("perm_calls_8byte", 64'(nstart - n0), 64'(6 - PRE));

    // Three-byte last word with garbage tail: absorbed delta
    init_s = ascon_p({IV, 256'd0});
    x0i = init_s[319:256];
    m = '{8'hAA, 8'hBB, 8'hCC};
    model_push(m);
    c0 = cap_log.size();
    pulse_start();
    send_word(64'hAABBCCFFFFFFFFFF, 1'b1, 4'd3);
    drain(1'b0);
    idx = c0 + 1 - PRE;
    if (idx < cap_log.size()) chk("absorb_delta", cap_log[idx][319:256] ^ x0i, 64'hAABBCC8000000000);
    else begin n_checks++; n_fail++; $display("FAIL absorb_delta: got no call expected one"); end

    // Digest stall on word 2
    m.delete();
    for (int i = 0; i < 12; i++) m.push_back(8'($urandom));
    run_hash(m, 1'b0, 1'b1);

    // start while busy, idle ABSORB, stray perm_fin
    m.delete();
    for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
    model_push(m);
    pulse_start();
    wait_ready();
    for (int i = 0; i < 30; i++) begin
      chk("msg_ready_hold", 64'(msg_ready), 64'd1);
      start = (i == 5);
      stray = (i == 10);
      tick();
    end
    start = 1'b0; stray = 1'b0;
    feed(m);
    drain(1'b0);

    // Reset during PWAIT of the second absorb
    n0 = nstart;
    pulse_start();
    send_word({$urandom, $urandom}, 1'b0, 4'd8);
    send_word({$urandom, $urandom}, 1'b0, 4'd8);
    for (int i = 0; i < 300 && (nstart - n0) < 3 - PRE; i++) tick();
    chk("reached_pwait2", 64'(nstart - n0), 64'(3 - PRE));
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dig_valid", 64'(dig_valid), 64'd0);
    chk("mid_rst_msg_ready", 64'(msg_ready), 64'd0);
    chk("mid_rst_perm_start", 64'(perm_start), 64'd0);
    rst = 1'b0;
    tick();
    m.delete();
    run_hash(m, 1'b1, 1'b0);

    // Random messages
    for (int t = 0; t < 8; t++) begin
      m.delete();
      for (int i = 0, n = $urandom_range(0, 40); i < n; i++) m.push_back(8'($urandom));
      run_hash(m, 1'b0, 1'b0);
    end

    chk("scoreboard_empty", 64'(exp_d.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_hash_ctrl.md
Name: ascon_hash_ctrl

Overview:
- Sponge controller for Ascon-Hash (256-bit digest, 64-bit rate); sits directly upstream of the 320-bit permutation core.
- Holds the state register and runs the permutation's start/fin handshake for init, absorb and squeeze.
- Absorbs a byte-granular message stream with 10* padding and streams four 64-bit digest words.
- Runs every permutation call with 12 rounds.

Parameters:
- ROUNDS, 12, value driven on perm_round (Ascon-Hash a=b=12)
- IV, 64'h00400c0000000100, initial x0 word

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin new hash; sampled in IDLE only
- busy  out  1  high whenever state != IDLE
- msg_valid  in  1  message word valid
- msg_ready  out  1  high only in ABSORB
- msg_data  in  64  message bytes, first byte in [63:56]
- msg_last  in  1  final message word
- msg_bytes  in  4  valid bytes in last word, 0..8; 9..15 treated as 8; ignored unless msg_last
- dig_valid  out  1  digest word valid
- dig_ready  in  1  consumer accepts digest word
- dig_data  out  64  digest word = x0
- dig_last  out  1  high with 4th digest word
- perm_clr  out  1  one-cycle pulse; top ORs it into the permutation reset
- perm_start  out  1  one-cycle pulse, cycle after perm_clr
- perm_round  out  5  constant ROUNDS
- perm_state  out  320  {x0,x1,x2,x3,x4}; stable from perm_clr until perm_fin
- perm_state_out  in  320  permuted state
- perm_fin  in  1  permutation done; perm_state_out valid this cycle

Behaviour:
- Reset values: busy, msg_ready, dig_valid, dig_last, perm_clr, perm_start = 0; dig_data = 0; state register = 0; FSM = IDLE; digest counter = 0.
- rst is synchronous and overrides everything, mid-operation included. The top also resets the permutation from rst, so there is no partial output after reset.
- FSM states: IDLE, LOAD, PCLR, PSTART, PWAIT, ABSORB, PAD, SQUEEZE.
- IDLE: start=1 -> LOAD. start while busy is ignored.
- LOAD: state <= {IV, 256'd0}; ret=ABS; -> PCLR.
- Permutation call: PCLR asserts perm_clr, PSTART asserts perm_start, PWAIT holds until perm_fin=1. That cycle: state <= perm_state_out, then branch on ret:
  - ABS -> ABSORB
  - PAD -> PAD
  - SQZ -> SQUEEZE
- ABSORB, msg_ready=1, on msg_valid&msg_ready:
  - Not last: x0 ^= msg_data; ret=ABS; -> PCLR.
  - Last with k=msg_bytes<8: x0 ^= (msg_data with low 8-k bytes zeroed) ^ (64'h80 << (56-8k)); ret=SQZ; -> PCLR.
  - k=0: data ignored, x0 ^= 64'h8000000000000000.
  - Last with k=8: x0 ^= msg_data; ret=PAD; -> PCLR.
- PAD: x0 ^= 64'h8000000000000000; ret=SQZ; -> PCLR.
- SQUEEZE:
  - dig_valid=1, dig_data=x0, dig_last=(cnt==3). Words are held stable while dig_ready=0.
  - On handshake with cnt<3: cnt++; ret=SQZ; -> PCLR.
  - On handshake with cnt==3: cnt=0 -> IDLE.
- msg_valid outside ABSORB and dig_ready outside SQUEEZE are ignored.
- perm_fin outside PWAIT is ignored.
- Permutation calls per hash: 1 init + N (message words) + 1 if k==8 + 3 squeeze.

Optional Feature:
- Macro ASCON_HASH_PRECOMP_IV_EN.
- Defined: LOAD writes the precomputed post-init state {64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62, 64'h43189921b8f8e3e8, 64'h348fa5c9d525e140} and goes straight to ABSORB, skipping the init permutation.
- Undefined: the init permutation runs as described in Behaviour.
- Digest output is identical either way.

Test Plan:
- Empty message (msg_last=1, msg_bytes=0) -> digest words 7346bc14f036e87a, e03d0997913088f5, f68411434b3cf8b5, 4fa796a80d251f91; dig_last only on the 4th.
- Single word 64'h0001020304050607, msg_bytes=8, msg_last=1 -> exactly 6 perm_start pulses (5 with ASCON_HASH_PRECOMP_IV_EN). Digest matches the software model for the 8-byte message 00..07.
- msg_bytes=3, msg_data=64'hAABBCCFFFFFFFFFF -> absorbed x0 delta = 64'hAABBCC8000000000.
- dig_ready held low 20 cycles on word 2 -> dig_data/dig_valid stable, no perm_start until the handshake.
- rst asserted during PWAIT of the 2nd absorb -> next cycle busy=0, dig_valid=0, FSM IDLE. A following hash of the empty message gives the correct digest.
- start pulsed while busy -> ignored, digest unaffected; with msg_valid=0, msg_ready stays 1 in ABSORB indefinitely.
